regfile_checker: RTL and testbench

- Synthesizable run-and-check harness that sits beside `top` in simulation or FPGA self-test builds.
- Lets the CPU run for a bounded window while counting taken jumps.
- Then scans a parametrised range of architectural registers through a 1-cycle-latency read port and compares them against an expected-value ROM.
- Link registers, selected by a mask, pass on any non-zero value; all other registers need an exact match. Reports pass/fail counts and the first failing index.

---
 rtl/chk_pkg.sv | 16 +
 rtl/regfile_checker_if.sv | 27 ++
 rtl/halt_detector.sv | 36 +++
 rtl/regfile_checker.sv | 153 +++++++++++++++
 tb/tb_regfile_checker.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chk_pkg.sv
// Shared types and constants for the register-file run-and-check harness.
package chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CHECK,
        DRAIN,
        DONE
    } chk_state_t;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] NO_FAIL = 5'h1F;
    localparam int CNT_W = 6;

endpackage

// File: rtl/regfile_checker_if.sv
// Debug read bus between the checker and the register file / expected ROM.
interface regfile_checker_if
    import chk_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic [REG_IDX_W-1:0] rf_addr;
    logic [XLEN-1:0]      rf_data;
    logic [REG_IDX_W-1:0] exp_addr;
    logic [XLEN-1:0]      exp_data;

    modport master (
        output rf_addr,
        output exp_addr,
        input  rf_data,
        input  exp_data
    );

    modport slave (
        input  rf_addr,
        input  exp_addr,
        output rf_data,
        output exp_data
    );

endinterface

// File: rtl/halt_detector.sv
// Flags the cycle in which the PC has been unchanged for HALT_STABLE cycles.
module halt_detector #(
    parameter int XLEN        = 32,
    parameter int HALT_STABLE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    output logic            halted
);

    localparam int CW = (HALT_STABLE > 1) ? $clog2(HALT_STABLE + 1) : 1;

    logic [XLEN-1:0] prev_pc;
    logic            have_prev;
    logic [CW-1:0]   cnt;
    logic            same;

    // have_prev keeps a stale PC from before RUN out of the compare
    assign same   = en && have_prev && (pc == prev_pc);
    assign halted = same && (cnt == CW'(HALT_STABLE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc   <= '0;
            have_prev <= 1'b0;
            cnt       <= '0;
        end else begin
            prev_pc   <= pc;
            have_prev <= en;
            cnt       <= same ? cnt + CW'(1) : '0;
        end
    end

endmodule

// File: rtl/regfile_checker.sv
// Runs the CPU for a bounded window, then scans and checks registers.
// Optional early exit on a stalled PC: define CHK_HALT_DETECT_EN.
module regfile_checker
    import chk_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_REGS    = 9,
    parameter int          BASE_REG    = 0,
    parameter int          RUN_CYCLES  = 100,
    parameter logic [31:0] LINK_MASK   = 32'h0000_0012,
    parameter int          HALT_STABLE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XLEN-1:0]      pc,
    input  logic                 jump,
    regfile_checker_if.master    rf,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic [REG_IDX_W-1:0] first_fail,
    output logic [15:0]          jump_count
`ifdef CHK_HALT_DETECT_EN
    ,
    output logic                 halted
`endif
);

    localparam int CYC_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST =
        CYC_W'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
    localparam logic [REG_IDX_W-1:0] BASE = REG_IDX_W'(BASE_REG);
    localparam logic [REG_IDX_W-1:0] LAST =
        REG_IDX_W'(BASE_REG + NUM_REGS - 1);

    chk_state_t           state, state_n;
    logic [CYC_W-1:0]     cyc;
    logic [REG_IDX_W-1:0] addr;
    logic [REG_IDX_W-1:0] cmp_idx;
    logic                 cmp_valid;
    logic                 cmp_ok;
    logic                 is_link;
    logic                 start_run;
    logic                 halt_hit;

`ifdef CHK_HALT_DETECT_EN
    halt_detector #(
        .XLEN        (XLEN),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt (
        .clk    (clk),
        .reset  (reset),
        .en     (state == RUN),
        .pc     (pc),
        .halted (halt_hit)
    );
`else
    localparam int unused_halt_stable = HALT_STABLE;
    logic unused_pc;
    assign unused_pc = ^pc;
    assign halt_hit  = 1'b0;
`endif

    assign rf.rf_addr  = addr;
    assign rf.exp_addr = addr;

    assign busy = (state == RUN) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (fail_count == '0);

    // x0 is never a link register, whatever the mask says
    assign is_link = LINK_MASK[cmp_idx] && (cmp_idx != '0);
    assign cmp_ok  = is_link ? (rf.rf_data != '0)
                             : (rf.rf_data == rf.exp_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_run = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_n   = (RUN_CYCLES == 0) ? CHECK : RUN;
                end
            end
            RUN: begin
                if (cyc == CYC_LAST || halt_hit) state_n = CHECK;
            end
            CHECK: begin
                if (addr == LAST) state_n = DRAIN;
            end
            DRAIN: state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc        <= '0;
            jump_count <= '0;
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= NO_FAIL;
            addr       <= BASE;
            cmp_valid  <= 1'b0;
            cmp_idx    <= '0;
        end else begin
            cmp_valid <= (state == CHECK);
            cmp_idx   <= addr;
            if (start_run) begin
                cyc        <= '0;
                jump_count <= '0;
                pass_count <= '0;
                fail_count <= '0;
                first_fail <= NO_FAIL;
                addr       <= BASE;
            end else begin
                if (state == RUN) begin
                    cyc <= cyc + CYC_W'(1);
                    if (jump && jump_count != 16'hFFFF)
                        jump_count <= jump_count + 16'd1;
                end
                if (state == CHECK)
                    addr <= (addr == LAST) ? BASE : addr + REG_IDX_W'(1);
                if (cmp_valid) begin
                    if (cmp_ok) begin
                        pass_count <= pass_count + CNT_W'(1);
                    end else begin
                        fail_count <= fail_count + CNT_W'(1);
                        if (first_fail == NO_FAIL) first_fail <= cmp_idx;
                    end
                end
            end
        end
    end

`ifdef CHK_HALT_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         halted <= 1'b0;
        else if (start_run)                 halted <= 1'b0;
        else if (state == RUN && halt_hit)  halted <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_regfile_checker.sv
// Directed bench for regfile_checker: default run plus a RUN_CYCLES=0 copy.
module tb_regfile_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_z;
    logic        jump;
    logic        freeze;
    logic [31:0] pc;

    logic        busy, done, pass;
    logic [5:0]  pass_count, fail_count;
    logic [4:0]  first_fail;
    logic [15:0] jump_count;

    logic        z_busy, z_done, z_pass;
    logic [5:0]  z_pass_count, z_fail_count;
    logic [4:0]  z_first_fail;
    logic [15:0] z_jump_count;

`ifdef CHK_HALT_DETECT_EN
    logic        halted;
    logic        z_halted;
`endif

    logic [31:0] rf_mem  [32];
    logic [31:0] exp_mem [32];

    int total;
    int bad;

    regfile_checker_if #(.XLEN(32)) bus ();
    regfile_checker_if #(.XLEN(32)) bus_z ();

    regfile_checker u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .pc         (pc),
        .jump       (jump),
        .rf         (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .first_fail (first_fail),
        .jump_count (jump_count)
`ifdef CHK_HALT_DETECT_EN
        ,
        .halted     (halted)
`endif
    );

    regfile_checker #(
        .RUN_CYCLES (0),
        .LINK_MASK  (32'h0000_0013)
    ) u_zero (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start_z),
        .pc         (pc),
        .jump       (jump),
        .rf         (bus_z),
        .busy       (z_busy),
        .done       (z_done),
        .pass       (z_pass),
        .pass_count (z_pass_count),
        .fail_count (z_fail_count),
        .first_fail (z_first_fail),
        .jump_count (z_jump_count)
`ifdef CHK_HALT_DETECT_EN
        ,
        .halted     (z_halted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file and expected ROM, both with one cycle of read latency
    always @(posedge clk) begin
        bus.rf_data    <= rf_mem[bus.rf_addr];
        bus.exp_data   <= exp_mem[bus.exp_addr];
        bus_z.rf_data  <= rf_mem[bus_z.rf_addr];
        bus_z.exp_data <= exp_mem[bus_z.exp_addr];
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!freeze) pc = pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic load_default();
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = (i == 0) ? 32'h0 : 32'h0000_0100 * i + 32'h11;
            exp_mem[i] = rf_mem[i];
        end
    endtask

    // pulse start, then count edges until done (bounded)
    task automatic run(input string tag, input int exp_cycles);
        int n;
        n = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        while (!done && n < 400) begin
            tick(1);
            n++;
        end
        chk({tag, "_latency"}, n, exp_cycles);
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        start_z = 1'b0;
        jump    = 1'b0;
        freeze  = 1'b0;
        pc      = 32'h0000_1000;
        load_default();
        tick(2);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_pcnt", pass_count, 0);
        chk("rst_fcnt", fail_count, 0);
        chk("rst_ffail", first_fail, 5'h1F);
        chk("rst_jcnt", jump_count, 0);
        chk("rst_addr", bus.rf_addr, 0);
        chk("rst_eaddr", bus.exp_addr, 0);

        rst_n = 1'b1;
        tick(2);

        // full run: jumps in RUN cycles 0, 10 and the last one (99)
        start = 1'b1;
        tick(1);
        start = 1'b0;
        jump = 1'b1;
        tick(1);
        jump = 1'b0;
        tick(9);
        jump = 1'b1;
        tick(1);
        jump = 1'b0;
        tick(40);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(46);
        chk("t1_busy_run", busy, 1);
        tick(1);
        jump = 1'b1;
        tick(1);
        jump = 1'b0;
        chk("t1_check_busy", busy, 1);
        chk("t1_jcnt", jump_count, 3);
        tick(9);
        chk("t1_not_done", done, 0);
        tick(1);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_pass", pass, 1);
        chk("t1_pcnt", pass_count, 9);
        chk("t1_fcnt", fail_count, 0);
        chk("t1_ffail", first_fail, 5'h1F);
        tick(3);
        chk("t1_hold", pass_count, 9);

        // link x1 mismatched but non-zero passes; link x4 zero fails
        rf_mem[1]  = 32'h0000_0008;
        exp_mem[1] = 32'h0000_0010;
        rf_mem[4]  = 32'h0;
        run("t2", 110);
        chk("t2_fcnt", fail_count, 1);
        chk("t2_pcnt", pass_count, 8);
        chk("t2_ffail", first_fail, 4);
        chk("t2_pass", pass, 0);
        chk("t2_jcnt", jump_count, 0);

        load_default();
        rf_mem[5]  = 32'hDEAD_BEEF;
        exp_mem[5] = 32'h0000_0005;
        rf_mem[7]  = 32'h0000_7777;
        run("t3", 110);
        chk("t3_fcnt", fail_count, 2);
        chk("t3_pcnt", pass_count, 7);
        chk("t3_ffail", first_fail, 5);
        chk("t3_pass", pass, 0);

        // reset in CHECK after four compares (x2 fails)
        load_default();
        rf_mem[2] = 32'h0000_0BAD;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(105);
        chk("t4_mid_pcnt", pass_count, 3);
        chk("t4_mid_fcnt", fail_count, 1);
        chk("t4_mid_ffail", first_fail, 2);
        chk("t4_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_pcnt", pass_count, 0);
        chk("t4_rst_fcnt", fail_count, 0);
        chk("t4_rst_ffail", first_fail, 5'h1F);
        chk("t4_rst_addr", bus.rf_addr, 0);
        tick(1);
        chk("t4_rst_done", done, 0);
        rst_n = 1'b1;
        rf_mem[2] = exp_mem[2];
        tick(1);
        run("t4_rerun", 110);
        chk("t4_pass", pass, 1);
        chk("t4_pcnt", pass_count, 9);
        chk("t4_fcnt", fail_count, 0);

        // RUN_CYCLES=0 copy: straight to CHECK, jump never counted
        start_z = 1'b1;
        jump    = 1'b1;
        tick(1);
        start_z = 1'b0;
        jump    = 1'b0;
        chk("t5_busy", z_busy, 1);
        chk("t5_addr0", bus_z.rf_addr, 0);
        tick(1);
        chk("t5_addr1", bus_z.rf_addr, 1);
        n = 1;
        while (!z_done && n < 100) begin
            tick(1);
            n++;
        end
        chk("t5_latency", n, 10);
        chk("t5_jcnt", z_jump_count, 0);
        chk("t5_pcnt", z_pass_count, 9);
        chk("t5_pass", z_pass, 1);

`ifdef CHK_HALT_DETECT_EN
        // PC stuck at 0x20 from RUN cycle 10: RUN exits in cycle 14
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        freeze = 1'b1;
        pc = 32'h0000_0020;
        tick(14);
        chk("t6_not_done", done, 0);
        tick(1);
        chk("t6_done", done, 1);
        chk("t6_halted", halted, 1);
        chk("t6_pcnt", pass_count, 9);
        chk("t6_fcnt", fail_count, 0);
        chk("t6_ffail", first_fail, 5'h1F);
        chk("t6_zhalted", z_halted, 0);
        freeze = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t6_halted_clr", halted, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
